// File: rtl/sort_div_seq_if.sv
// Request/result bundle for sort_div_seq: operand vector and mode in, one-cycle result strobe out.
interface sort_div_seq_if #(
    parameter int W = 4,
    parameter int N = 4
);
    logic             in_valid;
    logic [N*W-1:0]   in_data;
    logic             mode;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_n;
    logic             out_err;

    modport master (
        output in_valid, in_data, mode,
        input  in_ready, out_valid, out_n, out_err
    );

    modport slave (
        input  in_valid, in_data, mode,
        output in_ready, out_valid, out_n, out_err
    );
endinterface

// File: rtl/sort_div_seq.sv
// Sequential sorter plus calculator: sorts N unsigned operands into descending
// order with odd-even transposition (one pass per cycle), then either divides
// the largest by the smallest (restoring, one quotient bit per cycle) or sums
// the differences of adjacent sorted pairs (one pair per cycle).
module sort_div_seq #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    sort_div_seq_if.slave  bus
);

    localparam int CW = $clog2(N + W + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_s [N];
    logic [W-1:0]   w_pass [N];
    logic           r_mode;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_acc;
    logic           r_err;

    logic           w_sort_last;
    logic           w_calc_last;
    logic [W:0]     w_trial;
    logic [W:0]     w_divisor;
    logic           w_ge;
    logic [W:0]     w_sub;
    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_lo;
    logic [W-1:0]   w_diff;

    assign w_sort_last = (r_cnt == CW'(N - 1));
    assign w_calc_last = r_mode ? (r_cnt == CW'(N / 2 - 1)) : (r_cnt == CW'(W - 1));

    // One odd-even transposition pass: pairs starting at even or odd index, larger value moves down
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_pass[i] = r_s[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if ((((i % 2) != 0) == r_cnt[0]) && (r_s[i] < r_s[i+1])) begin
                w_pass[i]   = r_s[i+1];
                w_pass[i+1] = r_s[i];
            end
        end
    end

    // Restoring-division step: shift next dividend bit into the remainder and try the subtract.
    // A zero divisor always "fits", which yields the all-ones quotient for free.
    always_comb begin
        w_trial   = {r_rem, r_quo[W-1]};
        w_divisor = {1'b0, r_s[N-1]};
        w_ge      = (w_trial >= w_divisor);
        w_sub     = w_trial - w_divisor;
    end

    // Select the sorted pair (2j, 2j+1) addressed by the calc counter
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int j = 0; j < N / 2; j++) begin
            if (r_cnt == CW'(j)) begin
                w_hi = r_s[2*j];
                w_lo = r_s[2*j+1];
            end
        end
        w_diff = w_hi - w_lo;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_next = S_SORT;
            S_SORT: if (w_sort_last)  w_next = S_CALC;
            S_CALC: if (w_calc_last)  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: results are forced to zero outside the single DONE cycle
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.out_n     = '0;
        bus.out_err   = 1'b0;
        if (r_state == S_DONE) begin
            bus.out_n   = r_mode ? r_acc : r_quo;
            bus.out_err = r_err;
        end
    end

    // Datapath: capture operands, run sort passes, then divide or accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_s[k] <= '0;
            end
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_acc  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            r_s[k] <= bus.in_data[k*W +: W];
                        end
                        r_mode <= bus.mode;
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_quo  <= '0;
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_SORT: begin
                    r_s <= w_pass;
                    if (w_sort_last) begin
                        r_cnt <= '0;
                        // Dividend is the largest value, known once the final pass settles
                        r_quo <= w_pass[0];
                        r_err <= (w_pass[N-1] == '0) && !r_mode;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_mode) begin
                        r_acc <= r_acc + w_diff;
                    end else if (w_ge) begin
                        r_rem <= w_sub[W-1:0];
                        r_quo <= {r_quo[W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_trial[W-1:0];
                        r_quo <= {r_quo[W-2:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_div_seq.sv
// Self-checking bench for sort_div_seq: directed cases, hold-high and reset
// scenarios, plus random requests checked against a sort-and-compute model.
module tb_sort_div_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_div_seq_if #(.W(4), .N(4)) bus_a ();
    sort_div_seq_if #(.W(8), .N(6)) bus_b ();

    sort_div_seq #(.W(4), .N(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sort_div_seq #(.W(8), .N(6)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [47:0] d, input logic m);
        if (!sel) begin
            bus_a.in_valid = v; bus_a.in_data = d[15:0]; bus_a.mode = m;
        end else begin
            bus_b.in_valid = v; bus_b.in_data = d; bus_b.mode = m;
        end
    endtask

    task automatic sample(input bit sel, output logic ov, output logic ir,
                          output logic oe, output logic [7:0] on);
        ov = sel ? bus_b.out_valid : bus_a.out_valid;
        ir = sel ? bus_b.in_ready  : bus_a.in_ready;
        oe = sel ? bus_b.out_err   : bus_a.out_err;
        on = sel ? bus_b.out_n     : {4'b0, bus_a.out_n};
    endtask

    // Reference: sort the operands high-to-low, then apply the mode's rule arithmetically
    task automatic model(input bit sel, input logic [47:0] d, input logic m,
                         output int q, output int e);
        int w, n, mask;
        int s[$];
        logic [47:0] t;
        w = sel ? 8 : 4;
        n = sel ? 6 : 4;
        mask = (1 << w) - 1;
        s = {};
        for (int k = 0; k < n; k++) begin
            t = d >> (k * w);
            s.push_back(int'(t[7:0]) & mask);
        end
        s.rsort();
        q = 0;
        e = 0;
        if (m == 1'b0) begin
            if (s[n-1] == 0) begin
                q = mask; e = 1;
            end else begin
                q = s[0] / s[n-1];
            end
        end else begin
            for (int j = 0; j < n / 2; j++) q += s[2*j] - s[2*j+1];
        end
    endtask

    // Issue one request (entered just after a negedge) and check the whole transaction
    task automatic req(input bit sel, input logic [47:0] d, input logic m, input bit hold, input string tag);
        int q, e, lat, exp_lat, w, n;
        bit seen, zero_ok, busy_ok;
        logic ov, ir, oe;
        logic [7:0] on, got_n;
        logic got_e;
        w = sel ? 8 : 4;
        n = sel ? 6 : 4;
        model(sel, d, m, q, e);
        exp_lat = n + (m ? n / 2 : w) + 1;
        drive(sel, 1'b1, d, m);
        sample(sel, ov, ir, oe, on);
        chk({tag, "_ready"}, 32'(ir), 32'd1);
        @(posedge clk);
        lat = 0; seen = 0; zero_ok = 1; busy_ok = 1; got_n = '0; got_e = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (hold) drive(sel, 1'b1, {$urandom, $urandom}, 1'($urandom));
            else      drive(sel, 1'b0, '0, 1'b0);
            sample(sel, ov, ir, oe, on);
            if (ir !== 1'b0) busy_ok = 0;
            if (ov === 1'b1) begin
                seen = 1; lat = k; got_n = on; got_e = oe;
            end else if (on !== 8'd0 || oe !== 1'b0) begin
                zero_ok = 0;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out_n"}, 32'(got_n), 32'(q));
        chk({tag, "_out_err"}, 32'(got_e), 32'(e));
        chk({tag, "_quiet_busy"}, 32'({zero_ok, busy_ok}), 32'd3);
        @(negedge clk);
        sample(sel, ov, ir, oe, on);
        chk({tag, "_one_cycle"}, 32'({ov, ir}), 32'b01);
    endtask

    initial begin
        logic ov, ir, oe;
        logic [7:0] on;
        bit any_ov;
        logic [15:0] rd;

        // Reset with a simultaneous request: reset wins
        rst = 1'b1;
        drive(0, 1'b1, 48'h853C, 1'b0);
        drive(1, 1'b1, 48'h01FF5A5A0DC8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        sample(0, ov, ir, oe, on);
        chk("rst_a_outputs", 32'({ov, ir, oe, on}), 32'({1'b0, 1'b1, 1'b0, 8'd0}));
        sample(1, ov, ir, oe, on);
        chk("rst_b_outputs", 32'({ov, ir, oe, on}), 32'({1'b0, 1'b1, 1'b0, 8'd0}));
        rst = 1'b0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        any_ov = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) any_ov = 1;
        end
        chk("rst_priority_no_out", 32'(any_ov), 32'd0);

        // Directed cases at W=4, N=4
        req(0, 48'h853C, 1'b0, 0, "div_12_3");
        req(0, 48'h853C, 1'b1, 0, "sum_12_3_5_8");
        req(0, 48'h1F50, 1'b0, 0, "div_by_zero");
        req(0, 48'h7777, 1'b0, 0, "equal_div");
        req(0, 48'h7777, 1'b1, 0, "equal_sum");
        req(0, 48'hFFFF, 1'b0, 0, "all_max_div");
        req(0, 48'h0000, 1'b1, 0, "all_zero_sum");

        // in_valid held high with changing data: exactly one request per completion
        req(0, 48'h853C, 1'b0, 1, "hold_first");
        req(0, 48'h2961, 1'b1, 0, "hold_second");

        // Reset mid-operation aborts the request
        drive(0, 1'b1, 48'h853C, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(0, 1'b0, '0, 1'b0);
            if (k == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        sample(0, ov, ir, oe, on);
        chk("abort_ready", 32'({ov, ir}), 32'b01);
        any_ov = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus_a.out_valid !== 1'b0) any_ov = 1;
        end
        chk("abort_no_out", 32'(any_ov), 32'd0);
        req(0, 48'h853C, 1'b1, 0, "after_abort");

        // Wider instance W=8, N=6
        req(1, {8'd1, 8'd255, 8'd90, 8'd90, 8'd13, 8'd200}, 1'b0, 0, "b_div");
        req(1, {8'd1, 8'd255, 8'd90, 8'd90, 8'd13, 8'd200}, 1'b1, 0, "b_sum");

        // Random requests on both instances
        for (int r = 0; r < 20; r++) begin
            rd = 16'($urandom);
            if (r % 5 == 0) rd[4 +: 4] = 4'd0;
            req(0, {32'd0, rd}, 1'($urandom_range(0, 1)), 0, "rand_a");
        end
        for (int r = 0; r < 6; r++) begin
            req(1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, "rand_b");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
